// File: rtl/pc_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, state
// encodings, next-PC select and the fetch payload seen by decode.
package pc_seq_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NPC_HOLD  = 2'd0,
    NPC_INC   = 2'd1,
    NPC_REDIR = 2'd2
  } npc_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  // Redirect targets are forced onto a 4-byte boundary.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc.sv
// Program counter register with synchronous reset to RESET_PC.
module pc
  import pc_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_in;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/pc_seq.sv
// Instruction-fetch sequencer: one outstanding imem request, valid/ready hand-off
// to decode, and redirect handling that can squash an in-flight response.
module pc_seq
  import pc_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_instr,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [ILEN-1:0] fetch_instr,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            misalign_err
);

  state_e          state_q, state_d;
  logic            drop_q, drop_d;
  fetch_pkt_t      fetch_q, fetch_d;
  logic            req_valid_q, req_valid_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misalign_q, misalign_d;
  npc_sel_e        npc_sel;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] redir_tgt;

  pc u_pc (
    .clk    (clk),
    .reset  (reset),
    .pc_in  (pc_nxt),
    .pc_out (pc_cur)
  );

  assign redir_tgt = align_target(redirect_pc);

  // Next-state, drop flag, fetch capture and next-PC select.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    fetch_d = fetch_q;
    npc_sel = NPC_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          npc_sel = NPC_REDIR;
          if (imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
          drop_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid || drop_q) begin
            if (redirect_valid) begin
              npc_sel = NPC_REDIR;
            end
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            fetch_d.pc    = pc_cur;
            fetch_d.instr = imem_rsp_instr;
            npc_sel       = NPC_INC;
            state_d       = ST_HOLD;
          end
        end else if (redirect_valid) begin
          npc_sel = NPC_REDIR;
          drop_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        // A redirect wins over a same-cycle fetch_ready.
        if (redirect_valid) begin
          npc_sel = NPC_REDIR;
          state_d = ST_REQ;
        end else if (fetch_ready) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-PC mux feeding the pc register; PC+4 wraps modulo 2^XLEN.
  always_comb begin
    pc_nxt = pc_cur;
    unique case (npc_sel)
      NPC_INC:   pc_nxt = pc_cur + XLEN'(INSTR_BYTES);
      NPC_REDIR: pc_nxt = redir_tgt;
      default:   pc_nxt = pc_cur;
    endcase
  end

  // Output flags are registered off the next state so they align with it.
  always_comb begin
    req_valid_d   = (state_d == ST_REQ);
    fetch_valid_d = (state_d == ST_HOLD);
    misalign_d    = redirect_valid && is_misaligned(redirect_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      drop_q        <= 1'b0;
      fetch_q       <= '0;
      req_valid_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      fetch_q       <= fetch_d;
      req_valid_q   <= req_valid_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_cur;
  assign pc_out         = pc_cur;
  assign fetch_valid    = fetch_valid_q;
  assign fetch_pc       = fetch_q.pc;
  assign fetch_instr    = fetch_q.instr;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq; inputs change and outputs are
// sampled on the falling edge.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic [63:0] pc_out;
  logic        misalign_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_seq dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .fetch_ready    (fetch_ready),
    .pc_out         (pc_out),
    .misalign_err   (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_instr = 32'hFFFF_FFFF;
    fetch_ready = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0h want 0", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 64'h0) $display("FAIL rst_req_addr got %0h want 0", imem_req_addr); else passed++;
    total++; if (pc_out !== 64'h0) $display("FAIL rst_pc_out got %0h want 0", pc_out); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %0h want 0", fetch_valid); else passed++;
    total++; if (fetch_pc !== 64'h0) $display("FAIL rst_fetch_pc got %0h want 0", fetch_pc); else passed++;
    total++; if (fetch_instr !== 32'h0) $display("FAIL rst_fetch_instr got %0h want 0", fetch_instr); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL rst_misalign got %0h want 0", misalign_err); else passed++;
    reset = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_instr = '0;
    tick();
    total++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid got %0h want 1", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 64'h0) $display("FAIL first_req_addr got %0h want 0", imem_req_addr); else passed++;
  endtask

  // Zero-wait fetch from REQ: accept, respond, hand off; ends back in REQ.
  task automatic do_fetch(input logic [63:0] exp_pc, input logic [63:0] exp_next,
                          input logic [31:0] instr);
    total++; if (imem_req_addr !== exp_pc) $display("FAIL df_req_addr got %0h want %0h", imem_req_addr, exp_pc); else passed++;
    imem_req_ready = 1'b1; fetch_ready = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b0) $display("FAIL df_wait_req_valid got %0h want 0", imem_req_valid); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL df_wait_fetch_valid got %0h want 0", fetch_valid); else passed++;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_instr = instr;
    tick();
    imem_rsp_valid = 1'b0;
    total++; if (fetch_valid !== 1'b1) $display("FAIL df_fetch_valid got %0h want 1", fetch_valid); else passed++;
    total++; if (fetch_pc !== exp_pc) $display("FAIL df_fetch_pc got %0h want %0h", fetch_pc, exp_pc); else passed++;
    total++; if (fetch_instr !== instr) $display("FAIL df_fetch_instr got %0h want %0h", fetch_instr, instr); else passed++;
    total++; if (pc_out !== exp_next) $display("FAIL df_pc_inc got %0h want %0h", pc_out, exp_next); else passed++;
    tick();
    total++; if (fetch_valid !== 1'b0) $display("FAIL df_fetch_valid_fall got %0h want 0", fetch_valid); else passed++;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL df_next_req_valid got %0h want 1", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== exp_next) $display("FAIL df_next_req_addr got %0h want %0h", imem_req_addr, exp_next); else passed++;
  endtask

  task automatic test_sequential();
    do_fetch(64'h0, 64'h4, 32'h0000_0013);
    do_fetch(64'h4, 64'h8, 32'h0010_0093);
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0000;
    tick();
    redirect_valid = 1'b0;
    total++; if (pc_out !== 64'h0000_0000_8000_0000) $display("FAIL rw_pc got %0h want 80000000", pc_out); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rw_req_valid got %0h want 0", imem_req_valid); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL rw_misalign got %0h want 0", misalign_err); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    total++; if (fetch_valid !== 1'b0) $display("FAIL rw_dropped_fetch_valid got %0h want 0", fetch_valid); else passed++;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL rw_req_valid2 got %0h want 1", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 64'h0000_0000_8000_0000) $display("FAIL rw_req_addr got %0h want 80000000", imem_req_addr); else passed++;
    do_fetch(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004, 32'h0000_0013);
  endtask

  task automatic test_hold_redirect();
    imem_req_ready = 1'b1; fetch_ready = 1'b0;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h0020_0113;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_instr = 32'h0;
    tick();
    tick();
    total++; if (fetch_valid !== 1'b1) $display("FAIL hr_stall_valid got %0h want 1", fetch_valid); else passed++;
    total++; if (fetch_pc !== 64'h0000_0000_8000_0004) $display("FAIL hr_stall_pc got %0h want 80000004", fetch_pc); else passed++;
    total++; if (fetch_instr !== 32'h0020_0113) $display("FAIL hr_stall_instr got %0h want 00200113", fetch_instr); else passed++;
    redirect_valid = 1'b1; redirect_pc = 64'h2004; fetch_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    total++; if (fetch_valid !== 1'b0) $display("FAIL hr_fetch_valid got %0h want 0", fetch_valid); else passed++;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL hr_req_valid got %0h want 1", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 64'h2004) $display("FAIL hr_req_addr got %0h want 2004", imem_req_addr); else passed++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL wr_req_valid got %0h want 1", imem_req_valid); else passed++;
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0000_006F);
    total++; if (imem_req_addr !== 64'h0) $display("FAIL wr_wrap_addr got %0h want 0", imem_req_addr); else passed++;
  endtask

  task automatic test_misalign_reset();
    redirect_valid = 1'b1; redirect_pc = 64'h1002; imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    total++; if (misalign_err !== 1'b1) $display("FAIL ma_pulse got %0h want 1", misalign_err); else passed++;
    total++; if (pc_out !== 64'h1000) $display("FAIL ma_pc got %0h want 1000", pc_out); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_instr = 32'hBAD0_0001;
    tick();
    imem_rsp_valid = 1'b0;
    total++; if (misalign_err !== 1'b0) $display("FAIL ma_pulse_end got %0h want 0", misalign_err); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL ma_dropped got %0h want 0", fetch_valid); else passed++;
    total++; if (imem_req_addr !== 64'h1000) $display("FAIL ma_req_addr got %0h want 1000", imem_req_addr); else passed++;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; reset = 1'b1;
    tick();
    total++; if (pc_out !== 64'h0) $display("FAIL mr_pc got %0h want 0", pc_out); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL mr_req_valid got %0h want 0", imem_req_valid); else passed++;
    reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_instr = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL mr_req_valid2 got %0h want 1", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 64'h0) $display("FAIL mr_req_addr got %0h want 0", imem_req_addr); else passed++;
    tick();
    total++; if (fetch_valid !== 1'b0) $display("FAIL mr_late_rsp got %0h want 0", fetch_valid); else passed++;
    total++; if (fetch_instr !== 32'h0) $display("FAIL mr_late_instr got %0h want 0", fetch_instr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_hold_redirect();
    test_wrap();
    test_misalign_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
